// File: rtl/odd_issue_ctrl.sv
// Odd-pipe issue control: 7-deep age scoreboard, RAW stall, forward-select generation.
// Issue is combinational from decode; in_ready drops while a hazard stands, except when a taken branch flushes the instruction.
module odd_issue_ctrl #(
  parameter int LAT_PERM = 4,
  parameter int LAT_LS   = 6,
  parameter int LAT_BR   = 1,
  parameter int MAX_AGE  = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_unit,
  input  logic [6:0]  in_rt_addr,
  input  logic        in_reg_write,
  input  logic [6:0]  in_ra_addr,
  input  logic [6:0]  in_rb_addr,
  input  logic [6:0]  in_rc_addr,
  input  logic        in_ra_use,
  input  logic        in_rb_use,
  input  logic        in_rc_use,
  input  logic        branch_taken,
  output logic        issue_valid,
  output logic [1:0]  issue_unit,
  output logic        issue_reg_write,
  output logic [2:0]  fwd_sel_ra,
  output logic [2:0]  fwd_sel_rb,
  output logic [2:0]  fwd_sel_rc,
  output logic [15:0] stall_count
);

  logic [MAX_AGE:1] r_vld;
  logic [6:0]       r_addr [1:MAX_AGE];
  logic [2:0]       r_lat  [1:MAX_AGE];
  logic [15:0]      r_stall_count;

  logic [6:0] w_src_addr [3];
  logic       w_src_use  [3];
  logic [2:0] w_sel      [3];
  logic [2:0] w_hz;
  logic       w_hazard;
  logic       w_issue;
  logic [1:0] w_unit;
  logic [2:0] w_lat;

  assign w_src_addr[0] = in_ra_addr;
  assign w_src_addr[1] = in_rb_addr;
  assign w_src_addr[2] = in_rc_addr;
  assign w_src_use[0]  = in_ra_use;
  assign w_src_use[1]  = in_rb_use;
  assign w_src_use[2]  = in_rc_use;

  // Scan oldest to youngest so the youngest match overwrites and shadows older ones.
  always_comb begin
    for (int s = 0; s < 3; s++) begin
      w_sel[s] = 3'd0;
      w_hz[s]  = 1'b0;
      for (int k = MAX_AGE; k >= 1; k--) begin
        if (w_src_use[s] && r_vld[k] && (r_addr[k] == w_src_addr[s])) begin
          w_sel[s] = 3'(k);
          w_hz[s]  = (3'(k) < r_lat[k]);
        end
      end
    end
  end

  always_comb begin
    w_unit = (in_unit == 2'd3) ? 2'd0 : in_unit;
    case (w_unit)
      2'd1:    w_lat = 3'(LAT_LS);
      2'd2:    w_lat = 3'(LAT_BR);
      default: w_lat = 3'(LAT_PERM);
    endcase
  end

  assign w_hazard        = |w_hz;
  assign w_issue         = ~reset & in_valid & ~w_hazard & ~branch_taken;
  assign issue_valid     = w_issue;
  assign in_ready        = ~reset & (~w_hazard | branch_taken);
  assign issue_unit      = w_issue ? w_unit : 2'd0;
  assign issue_reg_write = w_issue & in_reg_write;
  assign fwd_sel_ra      = w_issue ? w_sel[0] : 3'd0;
  assign fwd_sel_rb      = w_issue ? w_sel[1] : 3'd0;
  assign fwd_sel_rc      = w_issue ? w_sel[2] : 3'd0;
  assign stall_count     = r_stall_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld <= '0;
      for (int k = 1; k <= MAX_AGE; k++) begin
        r_addr[k] <= 7'd0;
        r_lat[k]  <= 3'd0;
      end
    end else begin
      for (int k = MAX_AGE; k >= 2; k--) begin
        r_vld[k]  <= r_vld[k-1];
        r_addr[k] <= r_addr[k-1];
        r_lat[k]  <= r_lat[k-1];
      end
      r_vld[1]  <= w_issue & in_reg_write;
      r_addr[1] <= in_rt_addr;
      r_lat[1]  <= w_lat;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_count <= 16'd0;
    end else if (in_valid && w_hazard && !branch_taken && (r_stall_count != 16'hFFFF)) begin
      r_stall_count <= r_stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_odd_issue_ctrl.sv
// Directed bench for odd_issue_ctrl: inputs change on the falling edge, outputs are checked 1ns later.
module tb_odd_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_unit;
  logic [6:0]  in_rt_addr;
  logic        in_reg_write;
  logic [6:0]  in_ra_addr, in_rb_addr, in_rc_addr;
  logic        in_ra_use, in_rb_use, in_rc_use;
  logic        branch_taken;
  logic        issue_valid;
  logic [1:0]  issue_unit;
  logic        issue_reg_write;
  logic [2:0]  fwd_sel_ra, fwd_sel_rb, fwd_sel_rc;
  logic [15:0] stall_count;

  int total = 0;
  int bad   = 0;

  odd_issue_ctrl dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_unit(in_unit),
    .in_rt_addr(in_rt_addr), .in_reg_write(in_reg_write),
    .in_ra_addr(in_ra_addr), .in_rb_addr(in_rb_addr), .in_rc_addr(in_rc_addr),
    .in_ra_use(in_ra_use), .in_rb_use(in_rb_use), .in_rc_use(in_rc_use),
    .branch_taken(branch_taken), .issue_valid(issue_valid), .issue_unit(issue_unit),
    .issue_reg_write(issue_reg_write),
    .fwd_sel_ra(fwd_sel_ra), .fwd_sel_rb(fwd_sel_rb), .fwd_sel_rc(fwd_sel_rc),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] u, input logic [6:0] rt, input logic wr,
                       input logic [6:0] ra, input logic rau, input logic [6:0] rb, input logic rbu,
                       input logic [6:0] rc, input logic rcu, input logic br);
    in_valid = v; in_unit = u; in_rt_addr = rt; in_reg_write = wr;
    in_ra_addr = ra; in_ra_use = rau; in_rb_addr = rb; in_rb_use = rbu;
    in_rc_addr = rc; in_rc_use = rcu; branch_taken = br;
  endtask

  task automatic idle_drain();
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (8) @(negedge clk);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset state with a valid, hazard-free instruction presented
    @(negedge clk);
    drive(1, 0, 7'd1, 1, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_iv", 16'(issue_valid), 16'd0);
    chk("rst_rdy", 16'(in_ready), 16'd0);
    chk("rst_wr", 16'(issue_reg_write), 16'd0);
    chk("rst_cnt", stall_count, 16'd0);

    // Perm producer r5, back-to-back consumer on ra
    @(negedge clk);
    reset = 1'b0;
    drive(1, 0, 7'd5, 1, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("p1_iv", 16'(issue_valid), 16'd1);
    chk("p1_wr", 16'(issue_reg_write), 16'd1);
    chk("p1_rdy", 16'(in_ready), 16'd1);
    @(negedge clk);
    drive(1, 0, 7'd10, 1, 7'd5, 1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      if (i > 1) @(negedge clk);
      #1;
      chk("c1_stall_rdy", 16'(in_ready), 16'd0);
      chk("c1_stall_iv", 16'(issue_valid), 16'd0);
    end
    chk("c1_stall_sel", 16'(fwd_sel_ra), 16'd0);
    @(negedge clk);
    #1;
    chk("c1_iv", 16'(issue_valid), 16'd1);
    chk("c1_sel", 16'(fwd_sel_ra), 16'd4);
    chk("c1_cnt", stall_count, 16'd3);
    idle_drain();

    // LS producer r9, consumer on rc, then late readers at ages 7 and 8
    drive(1, 1, 7'd9, 1, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("p2_unit", 16'(issue_unit), 16'd1);
    @(negedge clk);
    drive(1, 0, 7'd0, 0, 0, 0, 0, 0, 7'd9, 1, 0);
    for (int i = 1; i <= 5; i++) begin
      if (i > 1) @(negedge clk);
      #1;
      chk("c2_stall_rdy", 16'(in_ready), 16'd0);
    end
    @(negedge clk);
    #1;
    chk("c2_iv", 16'(issue_valid), 16'd1);
    chk("c2_sel", 16'(fwd_sel_rc), 16'd6);
    chk("c2_cnt", stall_count, 16'd8);
    @(negedge clk);
    drive(1, 0, 7'd0, 0, 7'd9, 1, 0, 0, 0, 0, 0);
    #1;
    chk("age7_iv", 16'(issue_valid), 16'd1);
    chk("age7_sel", 16'(fwd_sel_ra), 16'd7);
    @(negedge clk);
    #1;
    chk("age8_sel", 16'(fwd_sel_ra), 16'd0);
    idle_drain();

    // Br r3 then Perm (unit 3) r3: the younger Perm entry shadows the Br one
    drive(1, 2, 7'd3, 1, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("p3_br_unit", 16'(issue_unit), 16'd2);
    @(negedge clk);
    drive(1, 3, 7'd3, 1, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("p3_u3_iv", 16'(issue_valid), 16'd1);
    chk("p3_u3_unit", 16'(issue_unit), 16'd0);
    @(negedge clk);
    drive(1, 0, 7'd0, 0, 0, 0, 7'd3, 1, 0, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      if (i > 1) @(negedge clk);
      #1;
      chk("c3_stall_rdy", 16'(in_ready), 16'd0);
    end
    @(negedge clk);
    #1;
    chk("c3_iv", 16'(issue_valid), 16'd1);
    chk("c3_sel", 16'(fwd_sel_rb), 16'd4);
    chk("c3_cnt", stall_count, 16'd11);
    idle_drain();

    // Taken branch discards an instruction; nothing enters the scoreboard
    drive(1, 0, 7'd20, 1, 0, 0, 0, 0, 0, 0, 1);
    #1;
    chk("br_iv", 16'(issue_valid), 16'd0);
    chk("br_rdy", 16'(in_ready), 16'd1);
    chk("br_wr", 16'(issue_reg_write), 16'd0);
    @(negedge clk);
    drive(1, 0, 7'd0, 0, 7'd20, 1, 0, 0, 0, 0, 0);
    #1;
    chk("br_next_iv", 16'(issue_valid), 16'd1);
    chk("br_next_sel", 16'(fwd_sel_ra), 16'd0);
    // Taken branch during a hazard: consumed, not counted as a stall
    @(negedge clk);
    drive(1, 0, 7'd21, 1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(1, 0, 7'd0, 0, 7'd21, 1, 0, 0, 0, 0, 1);
    #1;
    chk("brhz_rdy", 16'(in_ready), 16'd1);
    chk("brhz_iv", 16'(issue_valid), 16'd0);
    @(negedge clk);
    branch_taken = 1'b0;
    #1;
    chk("brhz_next_rdy", 16'(in_ready), 16'd0);
    chk("brhz_cnt", stall_count, 16'd11);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("brhz_iss_sel", 16'(fwd_sel_ra), 16'd4);
    chk("brhz_iss_cnt", stall_count, 16'd13);
    idle_drain();

    // Reset asserted mid-stall
    drive(1, 0, 7'd7, 1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(1, 0, 7'd0, 0, 7'd7, 1, 0, 0, 0, 0, 0);
    #1;
    chk("rs_stall_rdy", 16'(in_ready), 16'd0);
    @(negedge clk);
    #1;
    chk("rs_pre_cnt", stall_count, 16'd14);
    reset = 1'b1;
    #1;
    chk("rs_iv", 16'(issue_valid), 16'd0);
    chk("rs_rdy", 16'(in_ready), 16'd0);
    chk("rs_sel", 16'(fwd_sel_ra), 16'd0);
    chk("rs_cnt", stall_count, 16'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rs_post_iv", 16'(issue_valid), 16'd1);
    chk("rs_post_sel", 16'(fwd_sel_ra), 16'd0);
    chk("rs_post_cnt", stall_count, 16'd0);
    idle_drain();

    // Self-dependent LS instruction keeps a hazard standing 5 of every 6 cycles
    drive(1, 1, 7'd5, 1, 7'd5, 1, 0, 0, 0, 0, 0);
    n = 0;
    while (stall_count !== 16'hFFFF && n < 80000) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    #1;
    chk("sat_reach", stall_count, 16'hFFFF);
    repeat (12) @(negedge clk);
    #1;
    chk("sat_hold", stall_count, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
